// File: rtl/ccsds_asm_pkg.sv
// Shared constants for the CCSDS ASM inserter: sync marker, FSM encoding and TM randomizer helpers.
package ccsds_asm_pkg;

  localparam logic [31:0] ASM_WORD = 32'h1ACFFC1D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ASM  = 2'd1,
    DATA = 2'd2
  } state_t;

  // h(x) = x^8 + x^7 + x^5 + x^3 + 1. With s[7] holding the next output bit,
  // the recurrence a(k+8) = a(k+7) ^ a(k+5) ^ a(k+3) ^ a(k) taps s[0], s[2], s[4], s[7].
  localparam logic [8:0] PN_POLY     = 9'h1A9;
  localparam logic [7:0] PN_TAP_MASK = 8'h95;
  localparam logic [7:0] PN_SEED     = 8'hFF;

  function automatic logic [7:0] pn_bit_step(input logic [7:0] s);
    return {s[6:0], ^(s & PN_TAP_MASK)};
  endfunction

  // Advance the generator by nbits (at most 32) output bits.
  function automatic logic [7:0] pn_advance(input logic [7:0] seed, input int nbits);
    logic [7:0] s;
    s = seed;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) s = pn_bit_step(s);
    end
    return s;
  endfunction

endpackage

// File: rtl/ccsds_pn_randomizer.sv
// CCSDS TM pseudo-randomizer: XORs a width-bit beat with the next width sequence bits, MSB earliest.
// Combinational data path; generator restarts from the seed whenever restart is high and steps on advance.
module ccsds_pn_randomizer
  import ccsds_asm_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             advance,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [7:0]       lfsr;
  logic [7:0]       cur;
  logic [7:0]       walk;
  logic [width-1:0] pn;

  assign cur = restart ? PN_SEED : lfsr;

  always_comb begin
    walk = cur;
    pn   = '0;
    for (int i = width - 1; i >= 0; i--) begin
      pn[i] = walk[7];
      walk  = pn_bit_step(walk);
    end
  end

  assign dout = din ^ pn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= PN_SEED;
    end else if (advance) begin
      lfsr <= pn_advance(cur, width);
    end
  end

endmodule

// File: rtl/ccsds_asm_inserter.sv
// Prepends the 32-bit ASM to each LDPC codeword; optional TM randomizer on codeword bits (CCSDS_ASM_RANDOMIZER_EN).
// One registered output stage, input beat visible the cycle after acceptance; input stalls while the output register is full.
module ccsds_asm_inserter
  import ccsds_asm_pkg::*;
#(
  parameter int          width    = 8,
  parameter int          cw_bits  = 8160,
  parameter logic [31:0] asm_word = ASM_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             frame_err
);

  localparam int ASM_BEATS = 32 / width;
  localparam int CW_BEATS  = cw_bits / width;
  localparam int MAX_BEATS = (CW_BEATS > ASM_BEATS) ? CW_BEATS : ASM_BEATS;
  localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  if ((32 % width) != 0 || (cw_bits % width) != 0) begin : g_bad_width
    $error("ccsds_asm_inserter: width must divide 32 and cw_bits");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_ok;
  logic             in_acc;
  logic             asm_last;
  logic             cw_last;
  logic [width-1:0] asm_beat;
  logic [width-1:0] cw_dat;

  // The output register may take a new word when it is empty or being drained this cycle.
  assign load_ok       = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = (state == DATA) & load_ok;
  assign in_acc        = s_axis_tvalid & s_axis_tready;
  assign asm_last      = (cnt == CNT_W'(ASM_BEATS - 1));
  assign cw_last       = (cnt == CNT_W'(CW_BEATS - 1));
  assign asm_beat      = asm_word[32 - width * (int'(cnt) + 1) +: width];

`ifdef CCSDS_ASM_RANDOMIZER_EN
  ccsds_pn_randomizer #(
    .width (width)
  ) u_pn (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (cnt == '0),
    .advance (in_acc),
    .din     (s_axis_tdata),
    .dout    (cw_dat)
  );
`else
  assign cw_dat = s_axis_tdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      // tlast is only checked; the counter alone decides where the frame ends.
      frame_err <= in_acc & (s_axis_tlast != cw_last);

      if (load_ok) m_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (s_axis_tvalid) state <= ASM;
        end

        ASM: begin
          if (load_ok) begin
            m_axis_tdata  <= asm_beat;
            m_axis_tuser  <= 1'b1;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            if (asm_last) begin
              cnt   <= '0;
              state <= DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (in_acc) begin
            m_axis_tdata  <= cw_dat;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= cw_last;
            m_axis_tvalid <= 1'b1;
            if (cw_last) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccsds_asm_inserter.sv
// Directed bench for ccsds_asm_inserter at width 8, (8160,7136) codeword: 4 ASM bytes + 1020 codeword bytes per frame.
module tb_ccsds_asm_inserter;

  localparam int W        = 8;
  localparam int CW_BITS  = 8160;
  localparam int CW_BEATS = 1020;
  localparam int FRAME    = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         m_axis_tuser;
  logic         frame_err;

  always #5 clk = ~clk;

  ccsds_asm_inserter #(
    .width    (W),
    .cw_bits  (CW_BITS),
    .asm_word (32'h1ACFFC1D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_err     (frame_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // source state
  int src_idx, src_sent, src_total, tlast_pos;
  bit pat_zero, rdy_mode;

  // sink model and statistics
  int          out_pos, frames_done, err_cnt, err_rise, stall_cnt, first_vld, cap_n;
  int          tlast_cyc[$];
  int          start_cyc[$];
  logic        prev_err, hold_vld;
  logic [9:0]  hold_bus;
  logic [7:0]  cap [0:2047];
  bit          pn_seq [0:254];
  logic [31:0] asm_ref = 32'h1ACFFC1D;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pn_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = pn_seq[(8*k + j) % 255];
    return b;
  endfunction

  // {tdata, tuser, tlast} expected at position pos of a frame
  function automatic logic [9:0] exp_beat(input int pos);
    logic [7:0] d;
    int k;
    if (pos < 4) begin
      d = asm_ref[31-8*pos -: 8];
      return {d, 1'b1, 1'b0};
    end
    k = pos - 4;
    d = pat_zero ? 8'h00 : 8'(k % 256);
`ifdef CCSDS_ASM_RANDOMIZER_EN
    d = d ^ pn_byte(k);
`endif
    return {d, 1'b0, (pos == FRAME-1)};
  endfunction

  task automatic observe();
    logic [9:0] bus;
    bus = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    if (hold_vld) begin
      check("stall_vld", m_axis_tvalid, 1);
      check("stall_hold", bus, hold_bus);
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      if (first_vld < 0) first_vld = cyc;
      if (out_pos == 0) start_cyc.push_back(cyc);
      check($sformatf("beat%0d", out_pos), bus, exp_beat(out_pos));
      if (cap_n < 2048) begin
        cap[cap_n] = m_axis_tdata;
        cap_n++;
      end
      if (out_pos == FRAME-1) begin
        tlast_cyc.push_back(cyc);
        frames_done++;
        out_pos = 0;
      end else begin
        out_pos++;
      end
    end
    if (m_axis_tvalid === 1'b1 && !m_axis_tready) stall_cnt++;
    hold_vld = (m_axis_tvalid === 1'b1) && !m_axis_tready;
    hold_bus = bus;
    if (frame_err === 1'b1) begin
      err_cnt++;
      if (!prev_err) err_rise++;
    end
    prev_err = (frame_err === 1'b1);
  endtask

  task automatic cycle();
    @(negedge clk);
    m_axis_tready = rdy_mode ? ((cyc % 5) < 3) : 1'b1;
    if (src_sent < src_total) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pat_zero ? 8'h00 : 8'(src_idx % 256);
      s_axis_tlast  = (src_idx == tlast_pos);
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tlast  = 1'b0;
    end
    #1;
    if (rst_n) observe();
    if (s_axis_tvalid && s_axis_tready) begin
      src_sent++;
      src_idx = (src_idx == CW_BEATS-1) ? 0 : src_idx + 1;
    end
    cyc++;
  endtask

  task automatic start_test(input int beats, input int tl_pos, input bit zero, input bit rdy);
    src_idx = 0; src_sent = 0; src_total = beats; tlast_pos = tl_pos;
    pat_zero = zero; rdy_mode = rdy;
    out_pos = 0; frames_done = 0; err_cnt = 0; err_rise = 0; stall_cnt = 0;
    first_vld = -1; cap_n = 0; hold_vld = 1'b0; prev_err = 1'b0;
    tlast_cyc.delete();
    start_cyc.delete();
  endtask

  task automatic run_frames(input string tag, input int n, input int budget);
    int g;
    g = 0;
    while (frames_done < n && g < budget) begin
      cycle();
      g++;
    end
    check({tag, "_frames"}, frames_done, n);
  endtask

  task automatic idle_check(input string tag, input int n_frames);
    for (int i = 0; i < 6; i++) cycle();
    check({tag, "_extra_beats"}, start_cyc.size(), n_frames);
    check({tag, "_idle_vld"}, m_axis_tvalid, 0);
    check({tag, "_idle_rdy"}, s_axis_tready, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s_rdy"}, s_axis_tready, 0);
    check({tag, "_m_vld"}, m_axis_tvalid, 0);
    check({tag, "_m_dat"}, m_axis_tdata, 0);
    check({tag, "_m_user"}, m_axis_tuser, 0);
    check({tag, "_m_last"}, m_axis_tlast, 0);
    check({tag, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    logic [63:0] pn_head;

    for (int i = 0; i < 8; i++) pn_seq[i] = 1'b1;
    for (int i = 8; i < 255; i++) pn_seq[i] = pn_seq[i-1] ^ pn_seq[i-3] ^ pn_seq[i-5] ^ pn_seq[i-8];

    rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    start_test(0, CW_BEATS-1, 1'b0, 1'b0);

    // reset state, then IDLE with no input
    cycle();
    cycle();
    check_zero("reset");
    rst_n = 1'b1;
    cycle();
    cycle();
    check("idle_s_rdy", s_axis_tready, 0);
    check("idle_m_vld", m_axis_tvalid, 0);

    // single frame, counting pattern, always ready
    start_test(CW_BEATS, CW_BEATS-1, 1'b0, 1'b0);
    run_frames("t1", 1, 3000);
    if (tlast_cyc.size() >= 1) check("t1_span", tlast_cyc[0] - first_vld + 1, FRAME);
    check("t1_ferr", err_cnt, 0);
    check("t1_consumed", src_sent, CW_BEATS);
    idle_check("t1", 1);

    // two back-to-back codewords
    start_test(2*CW_BEATS, CW_BEATS-1, 1'b0, 1'b0);
    run_frames("t2", 2, 5000);
    if (tlast_cyc.size() >= 2) begin
      check("t2_gap", start_cyc[1] - tlast_cyc[0], 2);
      check("t2_span", tlast_cyc[1] - first_vld + 1, 2*FRAME + 1);
    end
    check("t2_ferr", err_cnt, 0);
    idle_check("t2", 2);

    // 3-on/2-off downstream ready
    start_test(CW_BEATS, CW_BEATS-1, 1'b0, 1'b1);
    run_frames("t3", 1, 5000);
    check("t3_stalls_seen", stall_cnt > 0, 1);
    check("t3_ferr", err_cnt, 0);
    check("t3_consumed", src_sent, CW_BEATS);
    rdy_mode = 1'b0;
    idle_check("t3", 1);

    // tlast early on byte 1000 and missing on byte 1020
    start_test(CW_BEATS, 999, 1'b0, 1'b0);
    run_frames("t4", 1, 3000);
    idle_check("t4", 1);
    check("t4_ferr_cycles", err_cnt, 2);
    check("t4_ferr_pulses", err_rise, 2);
    if (tlast_cyc.size() >= 1) check("t4_span", tlast_cyc[0] - first_vld + 1, FRAME);

    // reset after codeword byte 500 has been accepted
    start_test(CW_BEATS, CW_BEATS-1, 1'b0, 1'b0);
    for (int g = 0; g < 2000 && src_sent < 501; g++) cycle();
    check("t5_reached_500", src_sent, 501);
    rst_n = 1'b0;
    #1;
    check_zero("t5_rst_now");
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_zero($sformatf("t5_rst%0d", i));
    end
    rst_n = 1'b1;
    start_test(CW_BEATS, CW_BEATS-1, 1'b0, 1'b0);
    run_frames("t5", 1, 3000);
    if (tlast_cyc.size() >= 1) check("t5_span", tlast_cyc[0] - first_vld + 1, FRAME);
    check("t5_ferr", err_cnt, 0);
    idle_check("t5", 1);

    // all-zero codewords, two frames: exposes the randomizer sequence when enabled
    start_test(2*CW_BEATS, CW_BEATS-1, 1'b1, 1'b0);
    run_frames("t6", 2, 5000);
    check("t6_ferr", err_cnt, 0);
`ifdef CCSDS_ASM_RANDOMIZER_EN
    pn_head = 64'hFF480EC09A0D70BC;
    for (int i = 0; i < 8; i++) check($sformatf("t6_pn%0d", i), cap[4+i], pn_head[63-8*i -: 8]);
    check("t6_pn_restart0", cap[FRAME+4], 8'hFF);
    check("t6_pn_restart1", cap[FRAME+5], 8'h48);
`else
    pn_head = 64'h0;
    check("t6_plain0", cap[4], pn_head[7:0]);
    check("t6_plain_f2", cap[FRAME+4], pn_head[7:0]);
`endif
    check("t6_asm_f2", {cap[FRAME], cap[FRAME+1], cap[FRAME+2], cap[FRAME+3]}, 32'h1ACFFC1D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
